transposer_buffer: RTL

// - Scratchpad responder on the far end of the transposer memory interface.
// - Services raddr/raddr_vld with rdata/rdata_vld after a fixed pipeline latency.
// - Absorbs waddr/wdata/wdata_vld writes; one read and one write may occur per cycle.
// - Keeps saturating access counters and a sticky address-error flag for bench/debug visibility.

---
 rtl/transposer_buffer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/transposer_buffer.sv
// rtl/transposer_buffer.sv - scratchpad line buffer serving the transposer memory interface
//
// Purpose:
//   Line-wide scratchpad. Each cycle it accepts at most one read and one write.
//   Reads return after a fixed RLAT-cycle pipeline, in issue order. Saturating
//   access counters and a sticky address-error flag are kept for debug.
//
// Ports:
//   clk         in   1        rising-edge clock
//   reset_n     in   1        asynchronous active-low reset
//   init_pulse  in   1        clears rd_cnt, wr_cnt and addr_err
//   raddr       in   AW       read line address
//   raddr_vld   in   1        read request, accepted every cycle it is high
//   rdata       out  BUFFD*8  read data line (held when no result arrives)
//   rdata_vld   out  1        rdata carries a result this cycle
//   waddr       in   AW       write line address
//   wdata       in   BUFFD*8  write data line
//   wdata_vld   in   1        write request, accepted every cycle it is high
//   rd_cnt      out  AW       saturating count of accepted reads
//   wr_cnt      out  AW       saturating count of accepted writes
//   addr_err    out  1        sticky, set by any access with addr >= DEPTH
//
// Configuration macro:
//   TRANSPOSER_BUFFER_RD_FWD_EN - when defined, a read and a write to the same
//   in-range line in the same cycle return the new wdata; otherwise the read
//   returns the old line contents.

module transposer_buffer #(
  parameter int AW    = 16,
  parameter int BUFFD = 64,
  parameter int DEPTH = 1024,
  parameter int RLAT  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 init_pulse,
  input  logic [AW-1:0]        raddr,
  input  logic                 raddr_vld,
  output logic [BUFFD*8-1:0]   rdata,
  output logic                 rdata_vld,
  input  logic [AW-1:0]        waddr,
  input  logic [BUFFD*8-1:0]   wdata,
  input  logic                 wdata_vld,
  output logic [AW-1:0]        rd_cnt,
  output logic [AW-1:0]        wr_cnt,
  output logic                 addr_err
);

  localparam int          DW      = BUFFD * 8;
  localparam int          IW      = $clog2(DEPTH);
  // One extra bit so that DEPTH == 2**AW compares correctly.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];

  logic          rd_oob;
  logic          wr_oob;
  logic [IW-1:0] ridx;
  logic [IW-1:0] widx;
  logic [DW-1:0] rd_line;

  assign rd_oob = ({1'b0, raddr} >= DEPTH_W);
  assign wr_oob = ({1'b0, waddr} >= DEPTH_W);
  assign ridx   = raddr[IW-1:0];
  assign widx   = waddr[IW-1:0];

  always_comb begin
    rd_line = mem_q[ridx];
`ifdef TRANSPOSER_BUFFER_RD_FWD_EN
    if (wdata_vld && !wr_oob && (waddr == raddr)) begin
      rd_line = wdata;
    end
`endif
  end

  // Line storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wdata_vld && !wr_oob) begin
      mem_q[widx] <= wdata;
    end
  end

  // Read pipeline: stage 0 samples the array at issue, stage RLAT-1 is the
  // output register. Data and the out-of-range flag move only with a valid
  // entry, so the output stage holds its last result between reads.
  logic [RLAT-1:0] vld_q;
  logic [RLAT-1:0] oob_q;
  logic [DW-1:0]   data_q [RLAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      oob_q <= '0;
      for (int k = 0; k < RLAT; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= raddr_vld;
      if (raddr_vld) begin
        data_q[0] <= rd_line;
        oob_q[0]  <= rd_oob;
      end
      for (int k = 1; k < RLAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          data_q[k] <= data_q[k-1];
          oob_q[k]  <= oob_q[k-1];
        end
      end
    end
  end

  assign rdata_vld = vld_q[RLAT-1];
  assign rdata     = oob_q[RLAT-1] ? '0 : data_q[RLAT-1];

  // Counters and error flag; init_pulse takes priority over a same-cycle access.
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          addr_err_q, addr_err_d;

  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    addr_err_d = addr_err_q;
    if (init_pulse) begin
      rd_cnt_d   = '0;
      wr_cnt_d   = '0;
      addr_err_d = 1'b0;
    end else begin
      if (raddr_vld && (rd_cnt_q != '1)) begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
      if (wdata_vld && (wr_cnt_q != '1)) begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
      if ((raddr_vld && rd_oob) || (wdata_vld && wr_oob)) begin
        addr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign rd_cnt   = rd_cnt_q;
  assign wr_cnt   = wr_cnt_q;
  assign addr_err = addr_err_q;

endmodule
